muldiv_sequencer: RTL and testbench

//   Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline.

---
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Serves mult/multu/div/divu plus mfhi/mflo/mthi/mtlo beside the EX-stage ALU.
module muldiv_sequencer #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mf_req,
   input  logic        mt_we,
   input  logic        hl_sel,
   output logic [31:0] mf_data,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [63:0]   acc_q;
   logic [31:0]   opb_q;
   logic [31:0]   rs_q;
   logic          is_div_q;
   logic          qneg_q;
   logic          rneg_q;
   logic          dz_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          busy_q;
   logic          done_q;
   logic          div0_q;

   logic          signed_op;
   logic [31:0]   rs_mag;
   logic [31:0]   rt_mag;
   logic [32:0]   mul_sum;
   logic [32:0]   div_rsh;
   logic [32:0]   div_diff;
   logic [63:0]   acc_d;
   logic [63:0]   prod_fix;
   logic [31:0]   quo_fix;
   logic [31:0]   rem_fix;
   logic [31:0]   hi_d;
   logic [31:0]   lo_d;

   // Signed ops run on magnitudes; the sign is restored in FIN.
   always_comb begin
      signed_op = ~op[0];
      rs_mag    = (signed_op && rs_val[31]) ? -rs_val : rs_val;
      rt_mag    = (signed_op && rt_val[31]) ? -rt_val : rt_val;
   end

   // acc holds {partial, multiplier} for mul and {remainder, quotient} for div.
   always_comb begin
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      div_rsh  = acc_q[63:31];
      div_diff = div_rsh - {1'b0, opb_q};
      if (is_div_q) begin
         acc_d = div_diff[32] ? {div_rsh[31:0], acc_q[30:0], 1'b0}
                              : {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
         acc_d = {mul_sum, acc_q[31:1]};
      end
   end

   // NOTE: every variable gets a value on every path here, so no latch is inferred.
   always_comb begin
      prod_fix = qneg_q ? -acc_q : acc_q;
      quo_fix  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
      rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];
      hi_d     = prod_fix[63:32];
      lo_d     = prod_fix[31:0];
      if (dz_q) begin
         hi_d = rs_q;
         lo_d = 32'hFFFF_FFFF;
      end else if (is_div_q) begin
         hi_d = rem_fix;
         lo_d = quo_fix;
      end
   end

   // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         rs_q     <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= CALC;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  acc_q    <= {32'd0, rs_mag};
                  opb_q    <= rt_mag;
                  rs_q     <= rs_val;
                  is_div_q <= op[1];
                  qneg_q   <= signed_op & (rs_val[31] ^ rt_val[31]);
                  rneg_q   <= signed_op & rs_val[31];
                  dz_q     <= op[1] & (rt_val == 32'd0);
               end else if (mt_we) begin
                  if (hl_sel) hi_q <= rs_val;
                  else        lo_q <= rs_val;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
               end
            end
            FIN: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               div0_q  <= div0_q | dz_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall   = busy_q | (state_q == FIN) |
                    ((start | mf_req | mt_we) & (state_q != IDLE));
   assign mf_data = hl_sel ? hi_q : lo_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign div0    = div0_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/div0/done-cycle queued at issue,
// checked by an independent monitor whenever done pulses.
module tb_muldiv_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mf_req;
   logic        mt_we;
   logic        hl_sel;
   logic [31:0] mf_data;
   logic        stall;
   logic        busy;
   logic        done;
   logic        div0;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        d0;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic div0_model = 1'b0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   muldiv_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
      .rt_val(rt_val), .mf_req(mf_req), .mt_we(mt_we), .hl_sel(hl_sel),
      .mf_data(mf_data), .stall(stall), .busy(busy), .done(done),
      .div0(div0), .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge (first busy cycle).
   task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic with_mt);
      exp_t e;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      mt_we  = with_mt;
      hl_sel = 1'b1;
      if (o[1] && b == 32'd0) div0_model = 1'b1;
      e.name = name;
      e.hi   = ehi;
      e.lo   = elo;
      e.d0   = div0_model;
      e.cyc  = cyc + 34;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      mt_we = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
               check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
               check({e.name, "_div0"}, 64'(div0), 64'(e.d0));
               check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, ns, n, bad, nd;
      reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      mf_req = 1'b0; mt_we = 1'b0; hl_sel = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div0", 64'(div0), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);

      // Latency: 32 busy cycles, stall also covers FIN.
      issue("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      nb = 0; ns = 0; n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy) nb++;
         if (stall) ns++;
         @(negedge clk);
         n++;
      end
      check("busy_cycles", 64'(nb), 64'd32);
      check("stall_cycles", 64'(ns), 64'd33);

      // Back-to-back issue in the cycle after FIN.
      issue("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      wait_done("mult_neg");
      issue("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      wait_done("div_neg");

      // start with mt_we: start wins, HI keeps its value.
      issue("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      check("start_wins_hi", 64'(hi), 64'hFFFF_FFFF);
      mt_we = 1'b1; hl_sel = 1'b0; rs_val = 32'h5555;
      @(negedge clk);
      mt_we = 1'b0;
      check("mt_ignored_busy", 64'(lo), 64'hFFFF_FFFD);
      wait_done("divu_100_7");

      issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      wait_done("div_ovf");
      issue("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
      wait_done("div_negdiv");
      issue("mult_minsq", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      wait_done("mult_minsq");
      issue("divu_zero", DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0);
      wait_done("divu_zero");
      issue("multu_sticky", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
      wait_done("multu_sticky");

      // mtlo / mthi and mf reads in IDLE.
      @(negedge clk);
      mt_we = 1'b1; hl_sel = 1'b0; rs_val = 32'hCAFE;
      @(negedge clk);
      mt_we = 1'b0;
      check("mtlo", 64'(lo), 64'hCAFE);
      mf_req = 1'b1; hl_sel = 1'b0;
      #1;
      check("mflo_data", 64'(mf_data), 64'hCAFE);
      check("mflo_nostall", 64'(stall), 64'd0);
      @(negedge clk);
      mf_req = 1'b0; mt_we = 1'b1; hl_sel = 1'b1; rs_val = 32'hBEEF;
      @(negedge clk);
      mt_we = 1'b0; mf_req = 1'b1; hl_sel = 1'b1;
      #1;
      check("mfhi_data", 64'(mf_data), 64'hBEEF);
      @(negedge clk);
      mf_req = 1'b0;

      // mfhi raised on cycle 5 of a mult: stalled through FIN, then sees the new HI.
      issue("mult_mf", MULT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      repeat (4) @(negedge clk);
      mf_req = 1'b1; hl_sel = 1'b1;
      n = 0; bad = 0;
      while (done !== 1'b1 && n < 100) begin
         if (!stall) bad++;
         n++;
         @(negedge clk);
      end
      check("mf_stall_gaps", 64'(bad), 64'd0);
      check("mf_stall_len", 64'(n), 64'd29);
      check("mf_release", 64'(stall), 64'd0);
      check("mf_new_hi", 64'(mf_data), 64'hFFFF_FFFF);
      @(negedge clk);
      mf_req = 1'b0;

      // mtlo then reset on cycle 10 of a div: aborted, registers cleared, no done.
      mt_we = 1'b1; hl_sel = 1'b0; rs_val = 32'hCAFE;
      @(negedge clk);
      mt_we = 1'b0;
      issue("div_abort", DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
      repeat (9) @(negedge clk);
      void'(sb.pop_back());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      div0_model = 1'b0;
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_div0", 64'(div0), 64'd0);
      check("abort_stall", 64'(stall), 64'd0);
      nd = 0;
      repeat (40) begin
         if (done) nd++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(nd), 64'd0);

      issue("divu_after_rst", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      wait_done("divu_after_rst");

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", 64'(sb.size()), 64'd0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
